lcd_spi_write: RTL and testbench



---
 rtl/lcd_spi_write_if.sv | 31 +++
 rtl/lcd_spi_write.sv | 195 +++++++++++++++++++
 tb/tb_lcd_spi_write.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_spi_write_if.sv
// ---------------------------------------------------------------------------
// lcd_spi_write_if
// Bundles the sequencer handshake and the panel SPI pins of lcd_spi_write.
//   en_write  : sequencer -> writer, a word is pending on data_in
//   data_in   : sequencer -> writer, [8] = DC, [7:0] = byte (MSB first)
//   wr_done   : writer -> sequencer, one-cycle pulse when the word has left
//   lcd_cs    : writer -> panel, chip select (active-low)
//   lcd_dc    : writer -> panel, data/command select
//   lcd_sclk  : writer -> panel, SPI clock (idles low, mode 0)
//   lcd_mosi  : writer -> panel, SPI data
// The master modport is the sequencer side; it also observes the pins.
// ---------------------------------------------------------------------------
interface lcd_spi_write_if;
  logic       en_write;
  logic [8:0] data_in;
  logic       wr_done;
  logic       lcd_cs;
  logic       lcd_dc;
  logic       lcd_sclk;
  logic       lcd_mosi;

  modport master (
    output en_write, data_in,
    input  wr_done, lcd_cs, lcd_dc, lcd_sclk, lcd_mosi
  );

  modport slave (
    input  en_write, data_in,
    output wr_done, lcd_cs, lcd_dc, lcd_sclk, lcd_mosi
  );
endinterface

// File: rtl/lcd_spi_write.sv
// ---------------------------------------------------------------------------
// lcd_spi_write
// Serialises 9-bit command/data words onto the 4-wire SPI bus of an
// ST7789-class panel. Bit 8 selects DC (0 = command, 1 = data); bits 7:0
// are shifted MSB first in SPI mode 0. All outputs are registered.
//
// Ports:
//   sys_clk_50MHz : system clock, rising edge
//   sys_rst_n     : asynchronous active-low reset
//   bus           : lcd_spi_write_if.slave (en_write, data_in, wr_done,
//                   lcd_cs, lcd_dc, lcd_sclk, lcd_mosi)
//
// Parameters:
//   SCK_DIV : SCK half-period in sys_clk cycles (1..15)
//   GAP_CYC : idle cycles after each wr_done before sampling again (2..7)
//
// Optional build macro:
//   LCD_SPI_CS_KEEP_EN : burst mode, CS stays low between words while the
//                        sequencer keeps en_write high at the end of a word.
// ---------------------------------------------------------------------------
module lcd_spi_write #(
  parameter int SCK_DIV = 2,
  parameter int GAP_CYC = 2
) (
  input logic            sys_clk_50MHz,
  input logic            sys_rst_n,
  lcd_spi_write_if.slave bus
);

  localparam logic [3:0] HALF_LAST = 4'(SCK_DIV - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE,
    S_GAP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [2:0] bit_q,   bit_d;
  logic [7:0] shift_q, shift_d;
  logic       high_q,  high_d;
  logic       cs_q,    cs_d;
  logic       dc_q,    dc_d;
  logic       sclk_q,  sclk_d;
  logic       mosi_q,  mosi_d;
  logic       done_q,  done_d;
  logic       cnt_end;

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that every pin comes straight from a flop. In SHIFT, high_q tells
  // which half of the current bit is running; SETUP doubles as bit 7's low
  // half, so SHIFT is entered directly in a high half.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    high_d  = high_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    cnt_end = (cnt_q == HALF_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (bus.en_write) begin
          shift_d = bus.data_in[7:0];
          cs_d    = 1'b0;
          dc_d    = bus.data_in[8];
          mosi_d  = bus.data_in[7];
          cnt_d   = 4'd0;
          state_d = S_SETUP;
        end
`ifdef LCD_SPI_CS_KEEP_EN
        else begin
          // A burst ends on the first idle cycle without a pending word.
          cs_d = 1'b1;
        end
`endif
      end

      S_SETUP: begin
        if (cnt_end) begin
          cnt_d   = 4'd0;
          bit_d   = 3'd7;
          high_d  = 1'b1;
          sclk_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_SHIFT: begin
        if (!cnt_end) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = 4'd0;
          if (high_q) begin
            sclk_d = 1'b0;
            high_d = 1'b0;
            if (bit_q == 3'd0) begin
              mosi_d  = 1'b0;
              state_d = S_HOLD;
            end else begin
              // shift_q[7] is the bit just sent, so [6] is the next one.
              bit_d   = bit_q - 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
              mosi_d  = shift_q[6];
            end
          end else begin
            sclk_d = 1'b1;
            high_d = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (cnt_end) begin
          cnt_d   = 4'd0;
          done_d  = 1'b1;
          state_d = S_DONE;
`ifdef LCD_SPI_CS_KEEP_EN
          cs_d    = ~bus.en_write;
`else
          cs_d    = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        cnt_d   = 4'd0;
        state_d = S_GAP;
      end

      S_GAP: begin
        // en_write is deliberately ignored here: the sequencer needs these
        // cycles to move its next word onto data_in.
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves the bus idle with CS released.
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      high_q  <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      high_q  <= high_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign bus.lcd_cs   = cs_q;
  assign bus.lcd_dc   = dc_q;
  assign bus.lcd_sclk = sclk_q;
  assign bus.lcd_mosi = mosi_q;
  assign bus.wr_done  = done_q;

endmodule

// File: tb/tb_lcd_spi_write.sv
// ---------------------------------------------------------------------------
// tb_lcd_spi_write
// Drives two writers (SCK_DIV=2 and SCK_DIV=1) and checks every output pin
// each cycle against a timing model computed from the word's latch cycle,
// plus an SPI slave capture on the SCK_DIV=2 instance.
// ---------------------------------------------------------------------------
module tb_lcd_spi_write;

  localparam int D0 = 2;
  localparam int G0 = 2;
  localparam int D1 = 1;
  localparam int G1 = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lcd_spi_write_if bus0 ();
  lcd_spi_write_if bus1 ();

  lcd_spi_write #(.SCK_DIV(D0), .GAP_CYC(G0)) dut (
    .sys_clk_50MHz (clk),
    .sys_rst_n     (rst_n),
    .bus           (bus0)
  );

  lcd_spi_write #(.SCK_DIV(D1), .GAP_CYC(G1)) dut1 (
    .sys_clk_50MHz (clk),
    .sys_rst_n     (rst_n),
    .bus           (bus1)
  );

  typedef struct packed {
    logic cs;
    logic dc;
    logic sclk;
    logic mosi;
    logic done;
  } pins_t;

  typedef struct {
    logic [8:0] word;
    int         hold;
    logic [7:0] exp_bits;
    logic       exp_dc;
    int         exp_lat;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state, one slot per instance.
  int         m_l    [2];
  int         m_idle [2];
  logic       m_have [2];
  logic       m_dch  [2];
  logic [8:0] m_w    [2];

  // SPI slave capture for instance 0.
  logic       prev0 = 1'b0;
  logic [7:0] cap_bits = 8'd0;
  logic       cap_dc = 1'b0;
  int         cap_edges = 0;
  int         hi_run = 0;
  logic [8:0] cap_q[$];
  int         edges_q[$];
  int         done_cyc0[$];
  int         done_cyc1[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Pins for cycle c from the word latched in cycle l: offset o counts from
  // the first cycle after the latch; each SCK half is d cycles, halves 0..15
  // cover bit 7 down to bit 0 (odd halves high), half 16 is the hold, and
  // wr_done follows at o = 17*d.
  function automatic pins_t expectPins(int c, int l, int d, logic have, logic [8:0] w, logic dch);
    pins_t p;
    int    o;
    int    h;
    p.cs   = 1'b1;
    p.dc   = dch;
    p.sclk = 1'b0;
    p.mosi = 1'b0;
    p.done = 1'b0;
    if (have && c > l) begin
      o = c - l - 1;
      if (o < 17 * d) begin
        p.cs = 1'b0;
        h = o / d;
        if (h < 16) begin
          p.sclk = (h % 2 == 1);
          p.mosi = w[7 - h / 2];
        end
      end else if (o == 17 * d) begin
        p.done = 1'b1;
      end
    end
    return p;
  endfunction

  task automatic modelStep(input int i, input pins_t act, input logic en, input logic [8:0] din);
    int    d;
    int    g;
    pins_t e;
    d = (i == 0) ? D0 : D1;
    g = (i == 0) ? G0 : G1;
    if (!rst_n) begin
      m_have[i] = 1'b0;
      m_dch[i]  = 1'b0;
      m_idle[i] = 0;
    end
    e = expectPins(cyc, m_l[i], d, m_have[i], m_w[i], m_dch[i]);
    checkOutput($sformatf("dut%0d_cs", i),      act.cs,   e.cs);
    checkOutput($sformatf("dut%0d_dc", i),      act.dc,   e.dc);
    checkOutput($sformatf("dut%0d_sclk", i),    act.sclk, e.sclk);
    checkOutput($sformatf("dut%0d_mosi", i),    act.mosi, e.mosi);
    checkOutput($sformatf("dut%0d_wr_done", i), act.done, e.done);
    if (rst_n && cyc >= m_idle[i] && en) begin
      m_l[i]    = cyc;
      m_w[i]    = din;
      m_dch[i]  = din[8];
      m_have[i] = 1'b1;
      m_idle[i] = cyc + 17 * d + 2 + g;
    end
  endtask

  task automatic monitorStep();
    if (!rst_n) begin
      prev0     = 1'b0;
      cap_bits  = 8'd0;
      cap_dc    = 1'b0;
      cap_edges = 0;
      hi_run    = 0;
    end else begin
      if (bus0.lcd_sclk && !prev0) begin
        cap_bits = {cap_bits[6:0], bus0.lcd_mosi};
        cap_dc   = bus0.lcd_dc;
        cap_edges++;
      end
      if (bus0.lcd_sclk) begin
        hi_run++;
      end else if (prev0) begin
        checkOutput("dut0_sck_high", hi_run, D0);
        hi_run = 0;
      end
      if (bus0.wr_done) begin
        cap_q.push_back({cap_dc, cap_bits});
        edges_q.push_back(cap_edges);
        done_cyc0.push_back(cyc);
        cap_edges = 0;
      end
      prev0 = bus0.lcd_sclk;
      if (bus1.wr_done) done_cyc1.push_back(cyc);
    end
  endtask

  // One clock: evaluate models and monitors at the falling edge, then step
  // to just after the next rising edge where stimulus is driven.
  task automatic tick();
    pins_t a0;
    pins_t a1;
    @(negedge clk);
    a0 = {bus0.lcd_cs, bus0.lcd_dc, bus0.lcd_sclk, bus0.lcd_mosi, bus0.wr_done};
    a1 = {bus1.lcd_cs, bus1.lcd_dc, bus1.lcd_sclk, bus1.lcd_mosi, bus1.wr_done};
    modelStep(0, a0, bus0.en_write, bus0.data_in);
    modelStep(1, a1, bus1.en_write, bus1.data_in);
    monitorStep();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic waitIdle0();
    int guard = 0;
    while (cyc < m_idle[0] && guard < 200) begin
      tick();
      guard++;
    end
  endtask

  task automatic applyStimulus(input logic [8:0] word, input int hold, output int lat_cyc);
    waitIdle0();
    bus0.data_in  = word;
    bus0.en_write = 1'b1;
    lat_cyc = cyc;
    repeat (hold) tick();
    bus0.en_write = 1'b0;
  endtask

  task automatic waitDone0(output int dcyc, output logic [8:0] word, output int edges);
    int guard = 0;
    while (done_cyc0.size() == 0 && guard < 200) begin
      tick();
      guard++;
    end
    checkOutput("wr_done_seen", done_cyc0.size() > 0, 1);
    if (done_cyc0.size() > 0) begin
      dcyc  = done_cyc0.pop_front();
      word  = cap_q.pop_front();
      edges = edges_q.pop_front();
    end else begin
      dcyc  = -1;
      word  = 9'h000;
      edges = 0;
    end
  endtask

  task automatic waitDone1(output int dcyc);
    int guard = 0;
    while (done_cyc1.size() == 0 && guard < 200) begin
      tick();
      guard++;
    end
    checkOutput("div1_wr_done_seen", done_cyc1.size() > 0, 1);
    dcyc = (done_cyc1.size() > 0) ? done_cyc1.pop_front() : -1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         l;
    int         dcy;
    int         dcy2;
    int         prev;
    int         e;
    int         nd;
    logic [8:0] w;
    logic [8:0] got;
    vec_t       vecs[6];
    logic [8:0] script[$];

    vecs[0] = '{9'h011, 1,  8'h11, 1'b0, 35};
    vecs[1] = '{9'h1A5, 1,  8'hA5, 1'b1, 35};
    vecs[2] = '{9'h000, 3,  8'h00, 1'b0, 35};
    vecs[3] = '{9'h1FF, 20, 8'hFF, 1'b1, 35};
    vecs[4] = '{9'h0AA, 1,  8'hAA, 1'b0, 35};
    vecs[5] = '{9'h155, 30, 8'h55, 1'b1, 35};

    for (int i = 0; i < 2; i++) begin
      m_l[i] = 0; m_idle[i] = 0; m_have[i] = 1'b0; m_dch[i] = 1'b0; m_w[i] = 9'h000;
    end
    bus0.en_write = 1'b0;
    bus0.data_in  = 9'h000;
    bus1.en_write = 1'b0;
    bus1.data_in  = 9'h000;
    rst_n = 1'b0;

    // Reset state.
    repeat (3) tick();
    checkOutput("reset_cs",      bus0.lcd_cs,   1);
    checkOutput("reset_sclk",    bus0.lcd_sclk, 0);
    checkOutput("reset_mosi",    bus0.lcd_mosi, 0);
    checkOutput("reset_dc",      bus0.lcd_dc,   0);
    checkOutput("reset_wr_done", bus0.wr_done,  0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Table-driven single words.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].word, vecs[i].hold, l);
      waitDone0(dcy, got, e);
      checkOutput("vec_latency", dcy - l, vecs[i].exp_lat);
      checkOutput("vec_bits",    got[7:0], vecs[i].exp_bits);
      checkOutput("vec_dc",      got[8],   vecs[i].exp_dc);
      checkOutput("vec_edges",   e, 8);
    end

    // Random words, random spacing, data_in scrambled mid-word.
    for (int i = 0; i < 25; i++) begin
      w = 9'($urandom_range(0, 511));
      repeat ($urandom_range(0, 4)) tick();
      applyStimulus(w, $urandom_range(1, 30), l);
      bus0.data_in = 9'($urandom_range(0, 511));
      waitDone0(dcy, got, e);
      checkOutput("rand_word",    got, w);
      checkOutput("rand_latency", dcy - l, 1 + 17 * D0);
      checkOutput("rand_edges",   e, 8);
    end

    // Sequencer script: en_write held high, next word presented two cycles
    // after each wr_done.
    script.delete();
    for (int i = 0; i < 90; i++) script.push_back(9'($urandom_range(0, 511)));
    waitIdle0();
    bus0.data_in  = script[0];
    bus0.en_write = 1'b1;
    prev = 0;
    for (int i = 0; i < 90; i++) begin
      waitDone0(dcy, got, e);
      checkOutput("seq_word",  got, script[i]);
      checkOutput("seq_edges", e, 8);
      if (i > 0) checkOutput("seq_period", dcy - prev, 2 + 17 * D0 + G0);
      prev = dcy;
      if (i == 89) begin
        bus0.en_write = 1'b0;
      end else begin
        tick();
        bus0.data_in = script[i + 1];
      end
    end
    repeat (60) tick();
    checkOutput("seq_extra_done", done_cyc0.size(), 0);

    // en_write dropped and data_in changed during bit 4.
    applyStimulus(9'h1C3, 13, l);
    bus0.data_in = 9'h0FF;
    waitDone0(dcy, got, e);
    checkOutput("abort_word",    got, 9'h1C3);
    checkOutput("abort_latency", dcy - l, 1 + 17 * D0);
    repeat (60) tick();
    checkOutput("abort_extra_done", done_cyc0.size(), 0);

    // Reset during bit 3's high half, then a clean restart.
    applyStimulus(9'h05A, 1, l);
    repeat (19) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_cs",      bus0.lcd_cs,   1);
    checkOutput("midrst_sclk",    bus0.lcd_sclk, 0);
    checkOutput("midrst_mosi",    bus0.lcd_mosi, 0);
    checkOutput("midrst_wr_done", bus0.wr_done,  0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (60) tick();
    checkOutput("midrst_no_done", done_cyc0.size(), 0);
    applyStimulus(9'h12C, 1, l);
    waitDone0(dcy, got, e);
    checkOutput("restart_word",    got, 9'h12C);
    checkOutput("restart_latency", dcy - l, 35);
    checkOutput("restart_edges",   e, 8);

    // SCK_DIV=1 instance: two back-to-back words with en_write held high.
    bus1.data_in  = 9'h036;
    bus1.en_write = 1'b1;
    l = cyc;
    waitDone1(dcy);
    checkOutput("div1_latency", dcy - l, 18);
    bus1.data_in = 9'h108;
    repeat (3) tick();
    bus1.en_write = 1'b0;
    waitDone1(dcy2);
    checkOutput("div1_spacing", dcy2 - dcy, 21);
    repeat (40) tick();
    nd = done_cyc1.size();
    checkOutput("div1_extra_done", nd, 0);

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
